alu_share_arbiter: RTL and testbench

//  Shares one ALU_all instance between two requesters, e.g. the MIPS EX stage (port 0)
//  and the AES key-expansion/round engine (port 1). Each port uses a valid/ready

---
 rtl/alu_share_arbiter.sv | 110 +++++++++++
 tb/tb_alu_share_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one external ALU between two valid/ready requesters; one op in flight.
// Accept at T, EXEC at T+1, response valid at T+2; response held until rsp_ready, then IDLE.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_ovf,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_ovf,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_data1,
    output logic [DATA_W-1:0] alu_data2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_overflow
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state;
    logic                last_grant;
    logic                gnt;
    logic [OP_W-1:0]     op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   res_q;
    logic                ovf_q;

    logic win0;
    logic win1;
    logic rsp_rdy;
    logic arith_op;

    // A tie goes to the port that was not served last.
    always_comb begin
        win0     = req0_valid && (!req1_valid || last_grant);
        win1     = req1_valid && (!req0_valid || !last_grant);
        rsp_rdy  = gnt ? rsp1_ready : rsp0_ready;
        arith_op = (op_q == '0) || (op_q == OP_W'(1));
    end

    assign req0_ready = !rst && (state == IDLE) && win0;
    assign req1_ready = !rst && (state == IDLE) && win1;

    assign rsp0_valid  = (state == RESP) && !gnt;
    assign rsp1_valid  = (state == RESP) && gnt;
    assign rsp0_result = rsp0_valid ? res_q : '0;
    assign rsp1_result = rsp1_valid ? res_q : '0;
    assign rsp0_ovf    = rsp0_valid && ovf_q;
    assign rsp1_ovf    = rsp1_valid && ovf_q;

    assign alu_op    = op_q;
    assign alu_data1 = a_q;
    assign alu_data2 = b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win0 || win1) begin
                        gnt   <= win1;
                        op_q  <= win1 ? req1_op : req0_op;
                        a_q   <= win1 ? req1_a  : req0_a;
                        b_q   <= win1 ? req1_b  : req0_b;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    // The ALU overflow flag is only meaningful for add/sub.
                    res_q <= alu_result;
                    ovf_q <= arith_op && alu_overflow;
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_rdy) begin
                        last_grant <= gnt;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vectors, scoreboard queues per port, separate monitor.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_ovf;
    logic [3:0]  req0_op;
    logic [31:0] req0_a, req0_b, rsp0_result;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_ovf;
    logic [3:0]  req1_op;
    logic [31:0] req1_a, req1_b, rsp1_result;
    logic [3:0]  alu_op;
    logic [31:0] alu_data1, alu_data2, alu_result;
    logic        alu_overflow;
    logic [31:0] sum, diff;

    alu_share_arbiter #(.DATA_W(32), .OP_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_ovf(rsp0_ovf),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_ovf(rsp1_ovf),
        .alu_op(alu_op), .alu_data1(alu_data1), .alu_data2(alu_data2),
        .alu_result(alu_result), .alu_overflow(alu_overflow)
    );

    always #5 clk = ~clk;

    // ALU stand-in; its raw flag reports add overflow for every non-sub opcode.
    always_comb begin
        sum  = alu_data1 + alu_data2;
        diff = alu_data1 - alu_data2;
        case (alu_op)
            4'b0000: alu_result = sum;
            4'b0001: alu_result = diff;
            4'b0010: alu_result = alu_data1 & alu_data2;
            4'b0011: alu_result = alu_data1 | alu_data2;
            4'b0100: alu_result = alu_data1 ^ alu_data2;
            4'b0101: alu_result = {31'b0, $signed(alu_data1) < $signed(alu_data2)};
            4'b0110: alu_result = alu_data1 << alu_data2[4:0];
            4'b0111: alu_result = alu_data1 >> alu_data2[4:0];
            4'b1000: alu_result = $signed(alu_data1) >>> alu_data2[4:0];
            default: alu_result = '0;
        endcase
        if (alu_op == 4'b0001)
            alu_overflow = (alu_data1[31] != alu_data2[31]) && (diff[31] != alu_data1[31]);
        else
            alu_overflow = (alu_data1[31] == alu_data2[31]) && (sum[31] != alu_data1[31]);
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc_cyc[2];
    int   hs_cyc[2];
    int   done_cnt = 0;
    logic seen[2];
    logic [31:0] held[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout/unexpected required=event", name);
    endtask

    function automatic logic rdy(input int p);
        return (p == 0) ? req0_ready : req1_ready;
    endfunction

    task automatic set_req(input int p, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // Holds a request until accepted; the expected response is queued at acceptance.
    task automatic issue(input int p, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic ovf,
                         input bit push);
        int   n;
        exp_t e;
        n = 0;
        set_req(p, 1'b1, op, a, b);
        #1;
        while (!rdy(p) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!rdy(p)) begin
            fail($sformatf("accept_timeout_port%0d", p));
            set_req(p, 1'b0, 4'h0, 32'h0, 32'h0);
            done_cnt++;
            return;
        end
        acc_cyc[p] = cyc;
        if (push) begin
            e.op = op; e.a = a; e.b = b; e.res = res; e.ovf = ovf; e.acc = cyc;
            if (p == 0) q0.push_back(e); else q1.push_back(e);
        end
        @(negedge clk);
        set_req(p, 1'b0, 4'h0, 32'h0, 32'h0);
        done_cnt++;
    endtask

    task automatic mon(input int p);
        logic v, r, o, oovf;
        logic [31:0] res, ores;
        exp_t e;
        v    = (p == 0) ? rsp0_valid  : rsp1_valid;
        r    = (p == 0) ? rsp0_ready  : rsp1_ready;
        o    = (p == 0) ? rsp0_ovf    : rsp1_ovf;
        res  = (p == 0) ? rsp0_result : rsp1_result;
        oovf = (p == 0) ? rsp1_ovf    : rsp0_ovf;
        ores = (p == 0) ? rsp1_result : rsp0_result;
        if (!v) begin
            seen[p] = 1'b0;
            return;
        end
        check($sformatf("other_port_result_p%0d", p), 64'(ores), 64'(0));
        check($sformatf("other_port_ovf_p%0d", p), 64'(oovf), 64'(0));
        if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            fail($sformatf("unexpected_rsp_port%0d", p));
            return;
        end
        if (p == 0) e = q0[0]; else e = q1[0];
        if (!seen[p]) begin
            seen[p] = 1'b1;
            held[p] = res;
            check($sformatf("latency_p%0d", p), 64'(cyc), 64'(e.acc + 2));
            check($sformatf("alu_op_p%0d", p), 64'(alu_op), 64'(e.op));
            check($sformatf("alu_data1_p%0d", p), 64'(alu_data1), 64'(e.a));
            check($sformatf("alu_data2_p%0d", p), 64'(alu_data2), 64'(e.b));
        end else begin
            check($sformatf("hold_result_p%0d", p), 64'(res), 64'(held[p]));
        end
        if (r) begin
            if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            check($sformatf("result_p%0d_op%0h", p, e.op), 64'(res), 64'(e.res));
            check($sformatf("ovf_p%0d_op%0h", p, e.op), 64'(o), 64'(e.ovf));
            hs_cyc[p] = cyc;
            seen[p]   = 1'b0;
        end
    endtask

    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            mon(0);
            mon(1);
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() + q1.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if ((q0.size() + q1.size()) != 0) fail("drain_timeout");
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req0_ready"}, 64'(req0_ready), 64'(0));
        check({tag, "_req1_ready"}, 64'(req1_ready), 64'(0));
        check({tag, "_rsp_valid"}, 64'({rsp0_valid, rsp1_valid}), 64'(0));
        check({tag, "_rsp_result"}, {rsp0_result, rsp1_result}, 64'(0));
        check({tag, "_rsp_ovf"}, 64'({rsp0_ovf, rsp1_ovf}), 64'(0));
        check({tag, "_alu_op"}, 64'(alu_op), 64'(0));
        check({tag, "_alu_data"}, {alu_data1, alu_data2}, 64'(0));
    endtask

    typedef struct {
        int          p;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    vec_t vecs[10] = '{
        '{1, 4'b0000, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b1},
        '{1, 4'b0010, 32'h7FFFFFFF, 32'h1,        32'h1,        1'b0},
        '{0, 4'b0001, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b1},
        '{0, 4'b0001, 32'h5,        32'h7,        32'hFFFFFFFE, 1'b0},
        '{1, 4'b1001, 32'h7FFFFFFF, 32'h1,        32'h0,        1'b0},
        '{0, 4'b1111, 32'h5,        32'h7,        32'h0,        1'b0},
        '{1, 4'b1000, 32'h80000000, 32'h4,        32'hF8000000, 1'b0},
        '{0, 4'b0101, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0},
        '{0, 4'b0101, 32'h3,        32'h5,        32'h1,        1'b0},
        '{0, 4'b0101, 32'h5,        32'h3,        32'h0,        1'b0}
    };

    initial begin
        int a0, a0b, a1, dc0, n;
        rst = 1'b1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        set_req(0, 1'b1, 4'h3, 32'h11, 32'h22);
        set_req(1, 1'b1, 4'h4, 32'h33, 32'h44);
        seen[0] = 1'b0;
        seen[1] = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        set_req(0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_req(1, 1'b0, 4'h0, 32'h0, 32'h0);
        rst = 1'b0;

        // Tie from reset goes to port 0; its immediate re-request then ties and loses to port 1.
        fork
            begin
                issue(0, 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b1);
                a0 = acc_cyc[0];
                issue(0, 4'b0011, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b1);
                a0b = acc_cyc[0];
            end
            begin
                issue(1, 4'b0100, 32'hFF, 32'h0F, 32'hF0, 1'b0, 1'b1);
                a1 = acc_cyc[1];
            end
        join
        check("tie_port1_after_port0", 64'(a1), 64'(a0 + 3));
        check("tie_port0_after_port1", 64'(a0b), 64'(a1 + 3));
        drain();

        issue(0, 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b1);
        drain();

        // Response backpressure on port 0 while port 1 waits.
        rsp0_ready = 1'b0;
        issue(0, 4'b0000, 32'd100, 32'd23, 32'd123, 1'b0, 1'b1);
        @(negedge clk);
        dc0 = done_cnt;
        fork
            issue(1, 4'b0001, 32'd10, 32'd3, 32'd7, 1'b0, 1'b1);
        join_none
        for (int i = 0; i < 5; i++) begin
            #1;
            check("req1_ready_blocked", 64'(req1_ready), 64'(0));
            check("rsp0_valid_held", 64'(rsp0_valid), 64'(1));
            @(negedge clk);
        end
        rsp0_ready = 1'b1;
        n = 0;
        while (done_cnt == dc0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_after_handshake", 64'(acc_cyc[1]), 64'(hs_cyc[0] + 1));
        drain();

        foreach (vecs[i]) begin
            issue(vecs[i].p, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ovf, 1'b1);
            drain();
        end

        // Reset during EXEC; port 0 was served last, so only reset can give port 0 the next tie.
        issue(0, 4'b0000, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
        rst = 1'b1;
        set_req(0, 1'b1, 4'h1, 32'h55, 32'h66);
        set_req(1, 1'b1, 4'h2, 32'h77, 32'h88);
        #1;
        check_all_zero("rst_exec");
        repeat (2) @(negedge clk);
        set_req(0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_req(1, 1'b0, 4'h0, 32'h0, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("no_rsp_after_reset", 64'({rsp0_valid, rsp1_valid}), 64'(0));
        end
        @(negedge clk);
        fork
            issue(0, 4'b0011, 32'h1, 32'h2, 32'h3, 1'b0, 1'b1);
            issue(1, 4'b0010, 32'h6, 32'h3, 32'h2, 1'b0, 1'b1);
        join
        check("reset_tie_port0_first", 64'(acc_cyc[1]), 64'(acc_cyc[0] + 3));
        drain();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "global timeout");
    end

endmodule
